case_1_prod_accum: RTL and testbench

- Downstream consumer of the case_1 signed 5x5->5 multiplier stage.
- Accepts a stream of truncated signed products through a valid/ready handshake.
- Accumulates one frame of programmable length with signed saturation, then presents the sum on a held valid/ready output.
- Controlled by an ap_ctrl_hs-style start/idle/ready/done protocol.

---
 rtl/case_1_prod_accum_pkg.sv | 18 +
 rtl/case_1_prod_accum_if.sv | 32 +++
 rtl/case_1_prod_accum_sat_add.sv | 27 ++
 rtl/case_1_prod_accum.sv | 96 +++++++++
 tb/tb_case_1_prod_accum.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/case_1_prod_accum_pkg.sv
// Shared widths, state encoding and saturation bounds for the case_1 product accumulator.
package case_1_accum_pkg;

    localparam int unsigned DIN_WIDTH = 5;
    localparam int unsigned ACC_WIDTH = 12;
    localparam int unsigned LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_e;

    // Signed accumulator limits: 2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1)
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

endpackage

// File: rtl/case_1_prod_accum_if.sv
// Control, product-stream and result signals between the accumulator and its environment.
interface case_1_prod_accum_if;
    import case_1_accum_pkg::*;

    logic                        ap_start;
    logic [LEN_WIDTH-1:0]        frame_len;
    logic                        ap_idle;
    logic                        ap_ready;
    logic                        ap_done;

    logic signed [DIN_WIDTH-1:0] din;
    logic                        din_vld;
    logic                        din_rdy;

    logic signed [ACC_WIDTH-1:0] dout;
    logic                        dout_vld;
    logic                        dout_rdy;
    logic                        ovf;

    // Environment side: starts frames, feeds products, accepts results
    modport master (
        output ap_start, frame_len, din, din_vld, dout_rdy,
        input  ap_idle, ap_ready, ap_done, din_rdy, dout, dout_vld, ovf
    );

    // Accumulator side
    modport slave (
        input  ap_start, frame_len, din, din_vld, dout_rdy,
        output ap_idle, ap_ready, ap_done, din_rdy, dout, dout_vld, ovf
    );

endinterface

// File: rtl/case_1_prod_accum_sat_add.sv
// Combinational signed saturating add of a narrow product onto the accumulator.
module case_1_sat_add
    import case_1_accum_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [DIN_WIDTH-1:0] addend,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);

    logic [ACC_WIDTH:0] wide;

    // One guard bit; overflow shows as the top two bits disagreeing
    always_comb begin
        wide = {acc[ACC_WIDTH-1], acc}
             + {{(ACC_WIDTH + 1 - DIN_WIDTH){addend[DIN_WIDTH-1]}}, addend};
        sat  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
        if (!sat) begin
            sum = wide[ACC_WIDTH-1:0];
        end else if (wide[ACC_WIDTH]) begin
            sum = ACC_MIN;
        end else begin
            sum = ACC_MAX;
        end
    end

endmodule

// File: rtl/case_1_prod_accum.sv
// Frame accumulator behind the case_1 multiplier: ap_ctrl_hs start, valid/ready product
// input, saturating sum held on a valid/ready output until accepted.
module case_1_prod_accum
    import case_1_accum_pkg::*;
(
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    case_1_prod_accum_if.slave  bus
);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] sum;
    logic                 sat;

    case_1_sat_add u_sat_add (
        .acc    (acc_q),
        .addend (bus.din),
        .sum    (sum),
        .sat    (sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state, datapath updates and handshake outputs
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        bus.ap_idle  = 1'b0;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        bus.din_rdy  = 1'b0;
        bus.dout_vld = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.ap_idle = 1'b1;
                // ap_ready must stay low while reset is held, even with ap_start high
                if (bus.ap_start && ap_rst_n) begin
                    bus.ap_ready = 1'b1;
                    len_d        = bus.frame_len;
                    acc_d        = '0;
                    count_d      = '0;
                    ovf_d        = 1'b0;
                    state_d      = (bus.frame_len != '0) ? S_ACCUM : S_EMIT;
                end
            end
            S_ACCUM: begin
                bus.din_rdy = 1'b1;
                if (bus.din_vld) begin
                    acc_d   = sum;
                    ovf_d   = ovf_q | sat;
                    count_d = count_q + LEN_WIDTH'(1);
                    if (count_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                bus.dout_vld = 1'b1;
                if (bus.dout_rdy) begin
                    bus.ap_done = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dout = acc_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_case_1_prod_accum.sv
// Directed bench for case_1_prod_accum: framing, saturation, stalls, back-pressure, reset.
module tb_case_1_prod_accum;
    import case_1_accum_pkg::*;

    logic ap_clk;
    logic ap_rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    case_1_prod_accum_if bus_if ();

    case_1_prod_accum dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus_if)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".idle"},     32'(bus_if.ap_idle),  1);
        chk({tag, ".ready"},    32'(bus_if.ap_ready), 0);
        chk({tag, ".done"},     32'(bus_if.ap_done),  0);
        chk({tag, ".din_rdy"},  32'(bus_if.din_rdy),  0);
        chk({tag, ".dout_vld"}, 32'(bus_if.dout_vld), 0);
        chk({tag, ".dout"},     32'(bus_if.dout),     0);
        chk({tag, ".ovf"},      32'(bus_if.ovf),      0);
    endtask

    task automatic start_frame(input string tag, input int len);
        @(negedge ap_clk);
        bus_if.ap_start  = 1'b1;
        bus_if.frame_len = LEN_WIDTH'(len);
        #1;
        chk({tag, ".ap_ready"}, 32'(bus_if.ap_ready), 1);
        chk({tag, ".ap_idle"},  32'(bus_if.ap_idle),  1);
        chk({tag, ".din_rdy0"}, 32'(bus_if.din_rdy),  0);
    endtask

    task automatic send_beat(input string tag, input int val);
        @(negedge ap_clk);
        bus_if.ap_start = 1'b0;
        bus_if.din_vld  = 1'b1;
        bus_if.din      = DIN_WIDTH'(val);
        #1;
        chk({tag, ".din_rdy"},  32'(bus_if.din_rdy),  1);
        chk({tag, ".no_vld"},   32'(bus_if.dout_vld), 0);
    endtask

    task automatic send_beats(input string tag, input int n, input int val);
        for (int i = 0; i < n; i++) begin
            send_beat(tag, val);
        end
    endtask

    task automatic expect_result(input string tag, input int exp, input int exp_ovf);
        @(negedge ap_clk);
        bus_if.ap_start = 1'b0;
        bus_if.din_vld  = 1'b0;
        #1;
        chk({tag, ".dout_vld"}, 32'(bus_if.dout_vld), 1);
        chk({tag, ".dout"},     32'(bus_if.dout),     exp);
        chk({tag, ".ovf"},      32'(bus_if.ovf),      exp_ovf);
        chk({tag, ".din_rdy"},  32'(bus_if.din_rdy),  0);
        chk({tag, ".no_done"},  32'(bus_if.ap_done),  0);
        @(negedge ap_clk);
        bus_if.dout_rdy = 1'b1;
        #1;
        chk({tag, ".ap_done"},  32'(bus_if.ap_done),  1);
        @(negedge ap_clk);
        bus_if.dout_rdy = 1'b0;
        #1;
        chk({tag, ".vld_off"},  32'(bus_if.dout_vld), 0);
        chk({tag, ".done_off"}, 32'(bus_if.ap_done),  0);
        chk({tag, ".idle"},     32'(bus_if.ap_idle),  1);
        chk({tag, ".dout_keep"}, 32'(bus_if.dout),    exp);
    endtask

    initial begin
        ap_rst_n         = 1'b0;
        bus_if.ap_start  = 1'b0;
        bus_if.frame_len = '0;
        bus_if.din       = '0;
        bus_if.din_vld   = 1'b0;
        bus_if.dout_rdy  = 1'b0;

        repeat (2) @(negedge ap_clk);
        #1;
        chk_reset("rst0");
        bus_if.ap_start = 1'b1;
        #1;
        chk("rst0.ready_gated", 32'(bus_if.ap_ready), 0);
        bus_if.ap_start = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // 3 - 2 + 7 - 1 = 7
        start_frame("t1", 4);
        send_beat("t1", 3);
        send_beat("t1", -2);
        send_beat("t1", 7);
        send_beat("t1", -1);
        expect_result("t1", 7, 0);

        // 200 * 15 = 3000 clamps to 2047; 200 * -16 = -3200 clamps to -2048
        start_frame("sat_pos", 200);
        send_beats("sat_pos", 200, 15);
        expect_result("sat_pos", 2047, 1);
        start_frame("sat_neg", 200);
        send_beats("sat_neg", 200, -16);
        expect_result("sat_neg", -2048, 1);

        // Empty frame goes straight to EMIT with cleared sum and flag
        start_frame("len0", 0);
        expect_result("len0", 0, 0);

        // Stalled input: 5 + (skip) - 3 + (skip) + 6 = 8, then back-pressure
        start_frame("stall", 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            bus_if.ap_start = 1'b0;
            bus_if.din_vld  = (i % 2 == 0);
            bus_if.din      = (i == 0) ? 5'sd5 : (i == 2) ? -5'sd3 : (i == 4) ? 5'sd6 : 5'sd15;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            bus_if.din_vld = 1'b1;
            bus_if.din     = 5'sd15;
            #1;
            chk("stall.hold_vld",  32'(bus_if.dout_vld), 1);
            chk("stall.hold_dout", 32'(bus_if.dout),     8);
            chk("stall.hold_done", 32'(bus_if.ap_done),  0);
        end
        expect_result("stall", 8, 0);

        // Asynchronous reset in the middle of a frame discards the partial sum
        start_frame("mid_rst", 5);
        send_beat("mid_rst", 6);
        send_beat("mid_rst", 6);
        @(negedge ap_clk);
        bus_if.din_vld = 1'b0;
        ap_rst_n       = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        start_frame("post_rst", 2);
        send_beat("post_rst", 4);
        send_beat("post_rst", 4);
        expect_result("post_rst", 8, 0);

        // ap_start held high; frame_len changed after acceptance must not matter
        start_frame("held", 2);
        @(negedge ap_clk);
        bus_if.frame_len = 8'd7;
        bus_if.din_vld   = 1'b1;
        bus_if.din       = 5'sd1;
        #1;
        chk("held.no_ready1", 32'(bus_if.ap_ready), 0);
        @(negedge ap_clk);
        bus_if.din = 5'sd2;
        #1;
        chk("held.no_ready2", 32'(bus_if.ap_ready), 0);
        @(negedge ap_clk);
        bus_if.din_vld  = 1'b0;
        bus_if.dout_rdy = 1'b1;
        #1;
        chk("held.dout",      32'(bus_if.dout),     3);
        chk("held.done",      32'(bus_if.ap_done),  1);
        chk("held.no_ready3", 32'(bus_if.ap_ready), 0);
        @(negedge ap_clk);
        bus_if.dout_rdy  = 1'b0;
        bus_if.frame_len = 8'd1;
        #1;
        chk("held.ready2", 32'(bus_if.ap_ready), 1);
        send_beat("held2", 5);
        expect_result("held2", 5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
